vga_sync_receiver: RTL and testbench

Receive side of the VGA timing interface driven by our timing generator. The block takes h_sync and v_sync, synchronises them, and recovers pixel coordinates and display-enable. It measures line and frame lengths, checks them against the configured 640x480 timing, and reports lock and timing errors. It is used for loop-back self-test of the generator and to time pixel capture on the receive side.

---
 rtl/vga_sync_receiver_if.sv | 24 ++
 rtl/vga_sync_receiver.sv | 165 ++++++++++++++++
 tb/tb_vga_sync_receiver.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_receiver_if.sv
// Sync inputs and recovered timing outputs of the VGA loop-back receiver.
// master drives the syncs (timing generator side); slave is the receiver.
interface vga_sync_receiver_if;
    logic       h_sync;
    logic       v_sync;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       frame_start;
    logic       locked;
    logic       timing_err;
    logic [9:0] h_total_meas;
    logic [9:0] v_total_meas;

    modport master (
        output h_sync, v_sync,
        input  x, y, de, frame_start, locked, timing_err, h_total_meas, v_total_meas
    );

    modport slave (
        input  h_sync, v_sync,
        output x, y, de, frame_start, locked, timing_err, h_total_meas, v_total_meas
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// Recovers pixel coordinates and display-enable from h_sync/v_sync, measures
// line/frame length and tracks lock against the configured timing.
module vga_sync_receiver #(
    parameter int unsigned HRES          = 640,
    parameter int unsigned VRES          = 480,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC        = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC        = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter int unsigned LOCK_FRAMES   = 2
) (
    input  logic               clk,
    input  logic               reset,
    vga_sync_receiver_if.slave vga
);
    localparam logic [9:0] H_TOTAL  = 10'(HRES + H_FRONT_PORCH + H_SYNC + H_BACK_PORCH);
    localparam logic [9:0] V_TOTAL  = 10'(VRES + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH);
    localparam logic [9:0] HA0      = 10'(H_SYNC + H_BACK_PORCH);
    localparam logic [9:0] HA1      = 10'(H_SYNC + H_BACK_PORCH + HRES);
    localparam logic [9:0] VA0      = 10'(V_SYNC + V_BACK_PORCH);
    localparam logic [9:0] VA1      = 10'(V_SYNC + V_BACK_PORCH + VRES);
    localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);
    localparam logic [9:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    logic       hs_s1, hs_s2, hs_prev;
    logic       vs_s1, vs_s2, vs_prev;
    logic       hs_fall, vs_fall;
    logic [9:0] h_cnt, v_cnt;
    logic [9:0] h_next, v_next;
    logic [9:0] h_total_meas, v_total_meas;
    logic       frame_start;
    logic       locked;
    logic       timing_err;
    logic       line_ok, frame_ok, timeout;
    logic       de;
    logic [3:0] good_cnt;
    logic [3:0] good_next;
    state_t     state;

    // Two-flop synchroniser plus a history flop for falling-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_s1   <= 1'b1;
            hs_s2   <= 1'b1;
            hs_prev <= 1'b1;
            vs_s1   <= 1'b1;
            vs_s2   <= 1'b1;
            vs_prev <= 1'b1;
        end else begin
            hs_s1   <= vga.h_sync;
            hs_s2   <= hs_s1;
            hs_prev <= hs_s2;
            vs_s1   <= vga.v_sync;
            vs_s2   <= vs_s1;
            vs_prev <= vs_s2;
        end
    end

    assign hs_fall   = hs_prev & ~hs_s2;
    assign vs_fall   = vs_prev & ~vs_s2;
    assign h_next    = h_cnt + 10'd1;
    assign v_next    = v_cnt + 10'd1;
    assign good_next = good_cnt + 4'd1;
    assign line_ok   = (h_next == H_TOTAL);
    assign frame_ok  = (v_next == V_TOTAL);
    assign timeout   = (h_cnt == CNT_MAX) || (v_cnt == CNT_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            h_total_meas <= '0;
            v_total_meas <= '0;
            frame_start  <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt        <= '0;
                h_total_meas <= h_next;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_next;
            end

            // A partial line before the v_sync edge still counts as a line.
            if (vs_fall) begin
                v_cnt        <= '0;
                v_total_meas <= v_next;
            end else if (hs_fall && (v_cnt != CNT_MAX)) begin
                v_cnt <= v_next;
            end

            frame_start <= vs_fall;
        end
    end

    // Coincident h/v edges are the generator's normal frame start, so a
    // v_sync edge suppresses the line check for that cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_UNLOCKED;
            good_cnt   <= '0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                ST_UNLOCKED: begin
                    if (vs_fall) begin
                        good_cnt <= '0;
                        state    <= ST_ACQUIRE;
                    end
                end
                ST_ACQUIRE: begin
                    if (vs_fall) begin
                        if (frame_ok) begin
                            good_cnt <= good_next;
                            if (good_next == LOCK_CNT) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            timing_err <= 1'b1;
                            good_cnt   <= '0;
                        end
                    end else if ((hs_fall && !line_ok) || timeout) begin
                        timing_err <= 1'b1;
                        state      <= ST_UNLOCKED;
                    end
                end
                ST_LOCKED: begin
                    if ((vs_fall && !frame_ok) ||
                        (!vs_fall && ((hs_fall && !line_ok) || timeout))) begin
                        timing_err <= 1'b1;
                        locked     <= 1'b0;
                        state      <= ST_UNLOCKED;
                    end
                end
                default: begin
                    locked <= 1'b0;
                    state  <= ST_UNLOCKED;
                end
            endcase
        end
    end

    always_comb begin
        de = locked && (h_cnt >= HA0) && (h_cnt < HA1) && (v_cnt >= VA0) && (v_cnt < VA1);
    end

    assign vga.x            = de ? (h_cnt - HA0) : '0;
    assign vga.y            = de ? (v_cnt - VA0) : '0;
    assign vga.de           = de;
    assign vga.frame_start  = frame_start;
    assign vga.locked       = locked;
    assign vga.timing_err   = timing_err;
    assign vga.h_total_meas = h_total_meas;
    assign vga.v_total_meas = v_total_meas;
endmodule

// File: tb/tb_vga_sync_receiver.sv
// Directed/randomised bench for vga_sync_receiver using a reduced timing so
// whole frames fit in a short run; expectations come from sync-edge timestamps.
module tb_vga_sync_receiver;
    localparam int HRES = 16, HFP = 2, HSW = 4, HBP = 3;
    localparam int VRES = 12, VFP = 1, VSW = 2, VBP = 3;
    localparam int LOCK_FRAMES = 2;
    localparam int H_TOTAL = HRES + HFP + HSW + HBP;
    localparam int V_TOTAL = VRES + VFP + VSW + VBP;
    localparam int HA0 = HSW + HBP, HA1 = HA0 + HRES;
    localparam int VA0 = VSW + VBP, VA1 = VA0 + VRES;
    localparam int HIST = 32768;

    typedef enum {M_UNLOCKED, M_ACQUIRE, M_LOCKED} mode_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    vga_sync_receiver_if vga();

    vga_sync_receiver #(
        .HRES(HRES), .VRES(VRES),
        .H_FRONT_PORCH(HFP), .H_SYNC(HSW), .H_BACK_PORCH(HBP),
        .V_FRONT_PORCH(VFP), .V_SYNC(VSW), .V_BACK_PORCH(VBP),
        .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .vga(vga)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int n = 0;
    logic hist_h [HIST];
    logic hist_v [HIST];
    bit rst_prev = 1'b0;

    // Reference state: time of last line start, lines since frame start.
    int last_h = 0, lines = 0, meas_h = 0, meas_v = 0, good = 0;
    mode_t mode = M_UNLOCKED;
    bit exp_err = 1'b0, exp_fs = 1'b0;
    int dut_errs = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 1023) ? 1023 : v;
    endfunction

    function automatic logic hs_at(input int i);
        return (i < 0) ? 1'b1 : hist_h[i];
    endfunction

    function automatic logic vs_at(input int i);
        return (i < 0) ? 1'b1 : hist_v[i];
    endfunction

    // A sync sample driven at step c that is a falling edge shows up as a
    // zeroed counter at step c+3.
    task automatic model_update();
        int hpre, vpre;
        bit hf, vf, tmo;
        exp_err = 1'b0;
        exp_fs  = 1'b0;
        if (!rst_prev) begin
            last_h = n; lines = 0; meas_h = 0; meas_v = 0; good = 0;
            mode = M_UNLOCKED;
        end else begin
            hpre = sat(n - 1 - last_h);
            vpre = lines;
            hf   = hs_at(n - 4) && !hs_at(n - 3);
            vf   = vs_at(n - 4) && !vs_at(n - 3);
            tmo  = (hpre == 1023) || (vpre == 1023);
            if (hf) begin
                meas_h = (hpre + 1) % 1024;
                last_h = n;
            end
            if (vf) begin
                meas_v = (vpre + 1) % 1024;
                lines  = 0;
                exp_fs = 1'b1;
            end else if (hf) begin
                lines = sat(lines + 1);
            end
            if (mode == M_UNLOCKED) begin
                if (vf) begin
                    mode = M_ACQUIRE;
                    good = 0;
                end
            end else if (vf) begin
                if (vpre + 1 == V_TOTAL) begin
                    if (mode == M_ACQUIRE) begin
                        good++;
                        if (good == LOCK_FRAMES) mode = M_LOCKED;
                    end
                end else begin
                    exp_err = 1'b1;
                    good = 0;
                    if (mode == M_LOCKED) mode = M_UNLOCKED;
                end
            end else if ((hf && (hpre + 1 != H_TOTAL)) || tmo) begin
                exp_err = 1'b1;
                mode = M_UNLOCKED;
            end
        end
    endtask

    task automatic check_all();
        int hn, vn, ex, ey;
        bit lk, ede;
        hn  = sat(n - last_h);
        vn  = lines;
        lk  = (mode == M_LOCKED);
        ede = lk && hn >= HA0 && hn < HA1 && vn >= VA0 && vn < VA1;
        ex  = ede ? hn - HA0 : 0;
        ey  = ede ? vn - VA0 : 0;
        if (vga.timing_err === 1'b1) dut_errs++;
        chk("locked", {31'b0, vga.locked}, {31'b0, lk});
        chk("de", {31'b0, vga.de}, {31'b0, ede});
        chk("x", {22'b0, vga.x}, 32'(ex));
        chk("y", {22'b0, vga.y}, 32'(ey));
        chk("timing_err", {31'b0, vga.timing_err}, {31'b0, exp_err});
        chk("frame_start", {31'b0, vga.frame_start}, {31'b0, exp_fs});
        chk("h_total_meas", {22'b0, vga.h_total_meas}, 32'(meas_h));
        chk("v_total_meas", {22'b0, vga.v_total_meas}, 32'(meas_v));
        if (lk && hn == HA0 && vn == VA0) begin
            chk("first_px_de", {31'b0, vga.de}, 32'd1);
            chk("first_px_x", {22'b0, vga.x}, 32'd0);
            chk("first_px_y", {22'b0, vga.y}, 32'd0);
        end
        if (lk && hn == HA1 - 1 && vn == VA1 - 1) begin
            chk("last_px_x", {22'b0, vga.x}, 32'(HRES - 1));
            chk("last_px_y", {22'b0, vga.y}, 32'(VRES - 1));
        end
        if (lk && hn == HA1 && vn == VA0 + 1) begin
            chk("past_line_de", {31'b0, vga.de}, 32'd0);
            chk("past_line_x", {22'b0, vga.x}, 32'd0);
        end
    endtask

    task automatic step(input logic hs, input logic vs, input logic rst);
        @(negedge clk);
        model_update();
        check_all();
        vga.h_sync = hs;
        vga.v_sync = vs;
        reset = rst;
        hist_h[n] = rst ? hs : 1'b1;
        hist_v[n] = rst ? vs : 1'b1;
        if (rst_prev && !rst) begin
            #1;
            chk("rst_locked", {31'b0, vga.locked}, 32'd0);
            chk("rst_de", {31'b0, vga.de}, 32'd0);
            chk("rst_x", {22'b0, vga.x}, 32'd0);
            chk("rst_y", {22'b0, vga.y}, 32'd0);
            chk("rst_err", {31'b0, vga.timing_err}, 32'd0);
            chk("rst_hmeas", {22'b0, vga.h_total_meas}, 32'd0);
        end
        rst_prev = rst;
        n++;
    endtask

    task automatic send_line(input int len, input bit vs_low);
        int hw;
        hw = $urandom_range(1, HSW + 2);
        for (int p = 0; p < len; p++) step((p < hw) ? 1'b0 : 1'b1, vs_low ? 1'b0 : 1'b1, 1'b1);
    endtask

    task automatic send_frame(input int nlines, input int bad_line, input int bad_len);
        int vw;
        vw = $urandom_range(1, VSW + 1);
        for (int l = 0; l < nlines; l++) send_line((l == bad_line) ? bad_len : H_TOTAL, l < vw);
    endtask

    int e0;

    initial begin
        vga.h_sync = 1'b1;
        vga.v_sync = 1'b1;
        for (int i = 0; i < HIST; i++) begin
            hist_h[i] = 1'b1;
            hist_v[i] = 1'b1;
        end

        // Reset held with syncs toggling, then released with idle syncs.
        for (int i = 0; i < 12; i++) step(1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);

        // Nominal frames: lock after the third frame start.
        e0 = dut_errs;
        for (int f = 0; f < 4; f++) send_frame(V_TOTAL, -1, 0);
        chk("nominal_locked", {31'b0, vga.locked}, 32'd1);
        chk("nominal_hmeas", {22'b0, vga.h_total_meas}, 32'(H_TOTAL));
        chk("nominal_vmeas", {22'b0, vga.v_total_meas}, 32'(V_TOTAL));
        chk("nominal_no_err", 32'(dut_errs - e0), 32'd0);

        // One short line while locked.
        e0 = dut_errs;
        send_frame(V_TOTAL, $urandom_range(1, V_TOTAL - 2), H_TOTAL - 1);
        chk("badline_err", 32'(dut_errs - e0), 32'd1);
        chk("badline_unlocked", {31'b0, vga.locked}, 32'd0);
        for (int f = 0; f < 3; f++) send_frame(V_TOTAL, -1, 0);
        chk("relock", {31'b0, vga.locked}, 32'd1);

        // h_sync stuck high while locked.
        e0 = dut_errs;
        send_line(H_TOTAL, 1'b1);
        send_line(H_TOTAL, 1'b1);
        for (int i = 0; i < 1100; i++) step(1'b1, 1'b1, 1'b1);
        chk("timeout_err", 32'(dut_errs - e0), 32'd1);
        chk("timeout_unlocked", {31'b0, vga.locked}, 32'd0);

        // Re-acquire, with a short frame during ACQUIRE.
        e0 = dut_errs;
        send_frame(V_TOTAL, -1, 0);
        send_frame(V_TOTAL - 1, -1, 0);
        send_frame(V_TOTAL, -1, 0);
        chk("shortframe_err", 32'(dut_errs - e0), 32'd1);
        chk("shortframe_unlocked", {31'b0, vga.locked}, 32'd0);
        send_frame(V_TOTAL, -1, 0);
        chk("one_good_unlocked", {31'b0, vga.locked}, 32'd0);
        send_frame(V_TOTAL, -1, 0);
        chk("two_good_locked", {31'b0, vga.locked}, 32'd1);

        // Reset mid-line while locked.
        e0 = dut_errs;
        send_line(H_TOTAL, 1'b1);
        for (int l = 0; l < 6; l++) send_line(H_TOTAL, 1'b0);
        for (int p = 0; p < HA0 + 5; p++) step((p < HSW) ? 1'b0 : 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(1'($urandom), 1'($urandom), 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1);
        chk("reset_no_err", 32'(dut_errs - e0), 32'd0);
        for (int f = 0; f < 3; f++) send_frame(V_TOTAL, -1, 0);
        chk("final_locked", {31'b0, vga.locked}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
